// File: rtl/csl_8bit.sv
// 8-bit carry-select adder/subtractor with a registered result.
// The low nibble is a ripple adder. The high nibble is computed twice in parallel,
// once for each possible carry-in, and c4 picks one. Output latency is one clock.

// 1-bit full adder
module csl_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule

// 4-bit ripple-carry adder built from full adders
module csl_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] carry;

    assign carry[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            csl_fa u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .c  (carry[gi]),
                .s  (s[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    assign co = carry[4];
endmodule

// Top level: cin selects the mode (0 = add, 1 = subtract) and is also the carry into bit 0
module csl_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       cin,
    output logic       COUT,
    output logic [7:0] sum,
    input  logic       clk,
    input  logic       rst
);
    logic [7:0] bx;
    logic [3:0] lo_sum;
    logic       c4;
    logic [3:0] hi_sum0;
    logic [3:0] hi_sum1;
    logic       hi_co0;
    logic       hi_co1;
    logic [7:0] sum_next;
    logic       cout_next;

    // In subtract mode, invert B; the +1 of two's complement comes in through cin
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bx
            assign bx[gi] = B[gi] ^ cin;
        end
    endgenerate

    csl_rca4 u_lo (
        .a  (A[3:0]),
        .b  (bx[3:0]),
        .ci (cin),
        .s  (lo_sum),
        .co (c4)
    );

    // Speculative upper nibbles; c4 never ripples into these adders
    csl_rca4 u_hi0 (
        .a  (A[7:4]),
        .b  (bx[7:4]),
        .ci (1'b0),
        .s  (hi_sum0),
        .co (hi_co0)
    );

    csl_rca4 u_hi1 (
        .a  (A[7:4]),
        .b  (bx[7:4]),
        .ci (1'b1),
        .s  (hi_sum1),
        .co (hi_co1)
    );

    // Carry-select muxes: c4 picks the matching upper result
    always_comb begin
        sum_next  = {hi_sum0, lo_sum};
        cout_next = hi_co0;
        if (c4) begin
            sum_next  = {hi_sum1, lo_sum};
            cout_next = hi_co1;
        end
    end

    // Output register; reset wins over loading a new result
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= 8'h00;
            COUT <= 1'b0;
        end else begin
            sum  <= sum_next;
            COUT <= cout_next;
        end
    end
endmodule

// File: tb/tb_csl_8bit.sv
// Directed and randomised bench for csl_8bit. It prints one line per named transaction.
`timescale 1ns/1ps
module tb_csl_8bit;
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;
    logic       COUT;
    logic [7:0] sum;
    logic       clk;
    logic       rst;

    int vectors;
    int miscompares;

    csl_8bit dut (
        .A    (A),
        .B    (B),
        .cin  (cin),
        .COUT (COUT),
        .sum  (sum),
        .clk  (clk),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the operands, then wait one edge and settle 1 ns past it
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c);
        A   = a;
        B   = b;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(8'hFF, 8'hFF, 1'b0);
        vectors++;
        if ({COUT, sum} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset: got COUT=%0b sum=%0d, want COUT=0 sum=0", COUT, sum);
        end else
            $display("reset: COUT=%0b sum=%0d", COUT, sum);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic       tc [6];
        logic [8:0] te [6];
        ta = '{8'd5, 8'd1, 8'd9, 8'h0F, 8'hFF, 8'd2};
        tb = '{8'd2, 8'd16, 8'd5, 8'h01, 8'h01, 8'd5};
        tc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        te = '{{1'b1, 8'd3}, {1'b0, 8'd17}, {1'b1, 8'd4},
               {1'b0, 8'h10}, {1'b1, 8'h00}, {1'b0, 8'hFD}};
        for (int i = 0; i < 6; i++) begin
            step(ta[i], tb[i], tc[i]);
            vectors++;
            if ({COUT, sum} !== te[i]) begin
                miscompares++;
                $display("FAIL directed[%0d] A=%0d B=%0d cin=%0b: got COUT=%0b sum=%0d, want COUT=%0b sum=%0d",
                         i, ta[i], tb[i], tc[i], COUT, sum, te[i][8], te[i][7:0]);
            end else
                $display("directed[%0d] A=%0d B=%0d cin=%0b: COUT=%0b sum=%0d", i, ta[i], tb[i], tc[i], COUT, sum);
        end
    endtask

    task automatic test_back_to_back();
        step(8'd9, 8'd5, 1'b1);
        vectors++;
        if ({COUT, sum} !== {1'b1, 8'd4}) begin
            miscompares++;
            $display("FAIL b2b_first: got COUT=%0b sum=%0d, want COUT=1 sum=4", COUT, sum);
        end else
            $display("b2b_first: COUT=%0b sum=%0d", COUT, sum);
        step(8'd3, 8'd5, 1'b0);
        vectors++;
        if ({COUT, sum} !== {1'b0, 8'd8}) begin
            miscompares++;
            $display("FAIL b2b_second: got COUT=%0b sum=%0d, want COUT=0 sum=8", COUT, sum);
        end else
            $display("b2b_second: COUT=%0b sum=%0d", COUT, sum);
    endtask

    task automatic test_boundary();
        int bad;
        step(8'd255, 8'd255, 1'b0);
        vectors++;
        if ({COUT, sum} !== {1'b1, 8'd254}) begin
            miscompares++;
            $display("FAIL ff_plus_ff: got COUT=%0b sum=%0d, want COUT=1 sum=254", COUT, sum);
        end else
            $display("ff_plus_ff: COUT=%0b sum=%0d", COUT, sum);
        // A == B in subtract mode must give zero with no borrow for every value
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            step(v[7:0], v[7:0], 1'b1);
            vectors++;
            if ({COUT, sum} !== {1'b1, 8'd0}) begin
                miscompares++;
                bad++;
                if (bad <= 5)
                    $display("FAIL a_eq_b A=B=%0d: got COUT=%0b sum=%0d, want COUT=1 sum=0", v, COUT, sum);
            end
        end
        $display("a_eq_b sweep: 256 values, %0d bad", bad);
    endtask

    task automatic test_mid_reset();
        step(8'd1, 8'd16, 1'b0);
        vectors++;
        if ({COUT, sum} !== {1'b0, 8'h11}) begin
            miscompares++;
            $display("FAIL pre_reset: got COUT=%0b sum=%0h, want COUT=0 sum=11", COUT, sum);
        end else
            $display("pre_reset: COUT=%0b sum=%0h", COUT, sum);
        // Assert reset between edges: the outputs must hold until the edge arrives
        rst = 1'b1;
        A   = 8'd200;
        B   = 8'd100;
        cin = 1'b0;
        #2;
        vectors++;
        if ({COUT, sum} !== {1'b0, 8'h11}) begin
            miscompares++;
            $display("FAIL reset_hold: got COUT=%0b sum=%0h, want COUT=0 sum=11", COUT, sum);
        end else
            $display("reset_hold: COUT=%0b sum=%0h", COUT, sum);
        step(8'd200, 8'd100, 1'b0);
        vectors++;
        if ({COUT, sum} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_clear: got COUT=%0b sum=%0d, want COUT=0 sum=0", COUT, sum);
        end else
            $display("reset_clear: COUT=%0b sum=%0d", COUT, sum);
        rst = 1'b0;
        step(8'd200, 8'd100, 1'b0);
        vectors++;
        if ({COUT, sum} !== {1'b1, 8'd44}) begin
            miscompares++;
            $display("FAIL post_reset: got COUT=%0b sum=%0d, want COUT=1 sum=44", COUT, sum);
        end else
            $display("post_reset: COUT=%0b sum=%0d", COUT, sum);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
        int         bad;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            c   = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b ^ {8{c}}} + {8'd0, c};
            step(a, b, c);
            vectors++;
            if ({COUT, sum} !== exp) begin
                miscompares++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random A=%0d B=%0d cin=%0b: got COUT=%0b sum=%0d, want COUT=%0b sum=%0d",
                             a, b, c, COUT, sum, exp[8], exp[7:0]);
            end
        end
        $display("random: 4000 vectors, %0d bad", bad);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        A   = 8'd0;
        B   = 8'd0;
        cin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_boundary();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/csl_8bit.md
CSL_8BIT -- requirements
Module: csl_8bit

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, carry-select block size fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 cin  input  1  mode select and carry-in: 0 = add (A+B), 1 = subtract (A-B, two's complement, i.e. A + ~B + 1).
REQ-007 COUT  output  1  registered carry-out of bit 7; in subtract mode 1 = no borrow (A >= B).
REQ-008 sum  output  8  registered 8-bit result, modulo 256.
REQ-009 Port order SHALL be A, B, cin, COUT, sum, clk, rst, so that positional connection of the first five ports is preserved.

Function
REQ-010 Effective B operand SHALL be Bx = B XOR {8{cin}}; carry into bit 0 SHALL be cin.
REQ-011 Lower nibble (bits 3:0) SHALL be a 4-bit ripple-carry adder of A[3:0], Bx[3:0], cin, producing c4.
REQ-012 Upper nibble (bits 7:4) SHALL be computed twice in parallel by two 4-bit ripple-carry adders, one with carry-in 0 and one with carry-in 1.
REQ-013 c4 SHALL select, via 2:1 muxes, the upper sum nibble and the carry-out from the matching upper adder; no ripple path from c4 into the upper adders.
REQ-014 Each ripple adder SHALL be built from 1-bit full adders: s = a^b^c, co = ab | c(a^b).
REQ-015 Combinational result SHALL equal {c8, s[7:0]} = A + Bx + cin as a 9-bit value for all 2^17 input combinations.
REQ-016 sum and COUT SHALL be registered on rising clk; latency exactly 1 cycle from inputs sampled at edge N to outputs valid after edge N.
REQ-017 No handshake; a new operation is accepted every cycle; outputs hold until the next edge.
REQ-018 Wrap-around: add overflow beyond 255 SHALL truncate sum to 8 bits with COUT=1; subtract with A<B SHALL yield (A-B) mod 256 with COUT=0.
REQ-019 Boundary: A=B in subtract mode SHALL give sum=0, COUT=1; A=255,B=255,cin=0 SHALL give sum=254, COUT=1.
REQ-020 No signed-overflow flag; signed interpretation is left to the consumer.

Reset
REQ-021 When rst=1 at a rising clk edge, sum SHALL become 8'h00 and COUT SHALL become 0, regardless of A, B, cin.
REQ-022 rst SHALL have priority over loading a new result; an operation sampled while rst=1 is discarded.
REQ-023 The first cycle after rst deasserts SHALL register the result of inputs present at that edge; no further warm-up.
REQ-024 Reset asserted mid-stream SHALL clear outputs at that edge; before the edge, outputs keep their prior value (synchronous behaviour only).

Verification
REQ-025 A=5, B=2, cin=1 -> after 1 edge: sum=3, COUT=1.
REQ-026 A=1, B=16, cin=0 -> sum=17, COUT=0.
REQ-027 A=9, B=5, cin=1 -> sum=4, COUT=1; then A=3, B=5, cin=0 -> sum=8, COUT=0 on the following edge.
REQ-028 Carry-select path: A=8'h0F, B=8'h01, cin=0 -> sum=8'h10, COUT=0; A=8'hFF, B=8'h01, cin=0 -> sum=8'h00, COUT=1; A=2, B=5, cin=1 -> sum=8'hFD, COUT=0.
REQ-029 Reset: outputs holding sum=8'h11 with rst=1 at next edge and A=200, B=100 -> sum=0, COUT=0; rst=0 at following edge -> sum=44, COUT=1.
REQ-030 Exhaustive/randomised check of all A, B, cin against the 9-bit reference A + (B^{8{cin}}) + cin with 1-cycle delay -> zero mismatches.
